// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, injector state encoding and the
// head-flit destination field used by both the injector and the router's
// routing decode.
package noc_pkg;

  localparam int FLIT_W = 4;

  // Destination field inside a head flit. The whole flit carries the
  // destination code today; the router decodes the same field.
  localparam int DEST_LSB = 0;
  localparam int DEST_W   = FLIT_W;

  typedef enum logic [1:0] {
    INJ_IDLE = 2'd0,
    INJ_HEAD = 2'd1,
    INJ_BODY = 2'd2
  } inj_state_e;

  // Builds a head flit from a destination code.
  function automatic logic [FLIT_W-1:0] make_head_flit(input logic [DEST_W-1:0] dest);
    logic [FLIT_W-1:0] flit;
    flit = '0;
    flit[DEST_LSB +: DEST_W] = dest;
    return flit;
  endfunction

endpackage

// File: rtl/noc_inj_stats.sv
// Saturating statistics counters for the local injector: completed packets
// and cycles spent presenting a flit to a full router FIFO.
module noc_inj_stats #(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pkt_done,
  input  logic              stall,
  output logic [STAT_W-1:0] pkt_sent,
  output logic [STAT_W-1:0] stall_cycles
);

  // Both counters stop at all-ones and only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_sent     <= '0;
      stall_cycles <= '0;
    end else begin
      if (pkt_done && (pkt_sent != {STAT_W{1'b1}}))
        pkt_sent <= pkt_sent + STAT_W'(1);
      if (stall && (stall_cycles != {STAT_W{1'b1}}))
        stall_cycles <= stall_cycles + STAT_W'(1);
    end
  end

endmodule

// File: rtl/noc_local_injector.sv
// Local packet injector for a routerv2 local input port.
// Accepts one packet per req_valid/req_ready handshake, then writes a head
// flit (destination) followed by PAYLOAD_FLITS payload flits, LSB nibble
// first, holding each flit while local_full is high.
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; a flit transfers on a rising edge where
// write_local is high and local_full is low. req_ready is high only in IDLE.
// Optional statistics (pkt_sent, stall_cycles) exist only when
// NOC_INJ_STATS_EN is defined.
// FLIT_W must match noc_pkg::FLIT_W (router port width).
module noc_local_injector #(
  parameter int FLIT_W        = noc_pkg::FLIT_W,
  parameter int PAYLOAD_FLITS = 3
`ifdef NOC_INJ_STATS_EN
  ,
  parameter int STAT_W        = 16
`endif
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [FLIT_W-1:0]               req_dest,
  input  logic [PAYLOAD_FLITS*FLIT_W-1:0] req_payload,
  input  logic                            local_full,
  output logic                            write_local,
  output logic [FLIT_W-1:0]               local_in,
  output logic                            busy,
  output logic [1:0]                      state_dbg
`ifdef NOC_INJ_STATS_EN
  ,
  output logic [STAT_W-1:0]               pkt_sent,
  output logic [STAT_W-1:0]               stall_cycles
`endif
);

  import noc_pkg::*;

  // Flit index counts payload nibbles; 4 bits covers up to 15 payload flits.
  localparam int IDX_W = 4;

  inj_state_e                      state, state_nxt;
  logic [IDX_W-1:0]                idx, idx_nxt, idx_inc;
  logic [PAYLOAD_FLITS*FLIT_W-1:0] payload_q, payload_nxt;
  logic                            wl_nxt, ready_nxt, busy_nxt;
  logic [FLIT_W-1:0]               flit_nxt;
  logic                            accept, last_flit;

  assign accept    = write_local & ~local_full;
  assign last_flit = (idx == IDX_W'(PAYLOAD_FLITS - 1));
  assign idx_inc   = idx + IDX_W'(1);
  assign state_dbg = state;

  // State and every output are registered so nothing downstream sees a
  // combinational path from local_full or req_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= INJ_IDLE;
      idx         <= '0;
      payload_q   <= '0;
      write_local <= 1'b0;
      local_in    <= '0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      payload_q   <= payload_nxt;
      write_local <= wl_nxt;
      local_in    <= flit_nxt;
      req_ready   <= ready_nxt;
      busy        <= busy_nxt;
    end
  end

  // Next-state and next-output decode; a stalled flit simply holds.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    payload_nxt = payload_q;
    wl_nxt      = write_local;
    flit_nxt    = local_in;
    case (state)
      INJ_IDLE: begin
        // local_full is ignored here; the head flit just waits if needed.
        if (req_valid) begin
          payload_nxt = req_payload;
          flit_nxt    = make_head_flit(req_dest);
          wl_nxt      = 1'b1;
          idx_nxt     = '0;
          state_nxt   = INJ_HEAD;
        end
      end
      INJ_HEAD: begin
        if (accept) begin
          flit_nxt  = payload_q[0 +: FLIT_W];
          idx_nxt   = '0;
          state_nxt = INJ_BODY;
        end
      end
      INJ_BODY: begin
        if (accept) begin
          if (!last_flit) begin
            idx_nxt  = idx_inc;
            flit_nxt = payload_q[int'(idx_inc)*FLIT_W +: FLIT_W];
          end else begin
            wl_nxt    = 1'b0;
            state_nxt = INJ_IDLE;
          end
        end
      end
      default: begin
        wl_nxt    = 1'b0;
        state_nxt = INJ_IDLE;
      end
    endcase
    ready_nxt = (state_nxt == INJ_IDLE);
    busy_nxt  = (state_nxt != INJ_IDLE);
  end

`ifdef NOC_INJ_STATS_EN
  logic pkt_done, stall;

  // A packet completes on acceptance of its last payload flit.
  assign pkt_done = (state == INJ_BODY) & accept & last_flit;
  assign stall    = write_local & local_full;

  noc_inj_stats #(
    .STAT_W(STAT_W)
  ) u_stats (
    .clk          (clk),
    .reset        (reset),
    .pkt_done     (pkt_done),
    .stall        (stall),
    .pkt_sent     (pkt_sent),
    .stall_cycles (stall_cycles)
  );
`endif

endmodule

// File: tb/tb_noc_local_injector.sv
// Bench for noc_local_injector: directed test-plan scenarios followed by
// randomized traffic checked against a flit-queue reference model.
module tb_noc_local_injector;

  import noc_pkg::*;

  localparam int FW = 4;
  localparam int PF = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [FW-1:0]   req_dest;
  logic [PF*FW-1:0] req_payload;
  logic            local_full;
  logic            write_local;
  logic [FW-1:0]   local_in;
  logic            busy;
  logic [1:0]      state_dbg;
`ifdef NOC_INJ_STATS_EN
  localparam int SW = 16;
  logic [SW-1:0]   pkt_sent;
  logic [SW-1:0]   stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: flits still owed to the router, in order.
  logic [FW-1:0] exp_q[$];
  bit            last_q[$];
  int            model_pkts = 0;
  int            model_stalls = 0;
  int            pushes = 0;
  bit            hs_seen = 1'b0;

  // Observation buffers for directed sequences.
  logic [FW-1:0] obs_q[$];
  logic [FW-1:0] want_q[$];

  noc_local_injector #(
    .FLIT_W        (FW),
    .PAYLOAD_FLITS (PF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dest     (req_dest),
    .req_payload  (req_payload),
    .local_full   (local_full),
    .write_local  (write_local),
    .local_in     (local_in),
    .busy         (busy),
    .state_dbg    (state_dbg)
`ifdef NOC_INJ_STATS_EN
    ,
    .pkt_sent     (pkt_sent),
    .stall_cycles (stall_cycles)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_seq(input string tag);
    check({tag, "_len"}, obs_q.size(), want_q.size());
    foreach (want_q[i])
      check(tag, (i < obs_q.size()) ? obs_q[i] : 4'hx, want_q[i]);
  endtask

  task automatic model_flush();
    exp_q.delete();
    last_q.delete();
    model_pkts   = 0;
    model_stalls = 0;
  endtask

  // Model: a request is taken whenever nothing is owed; the owed flit is
  // what must be on local_in, and it leaves the queue when local_full is low.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("mon_req_ready", req_ready, exp_q.size() == 0);
      check("mon_busy", busy, exp_q.size() != 0);
      check("mon_write_local", write_local, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("mon_flit", local_in, exp_q[0]);
        if (local_full) model_stalls++;
        else begin
          void'(exp_q.pop_front());
          if (last_q.pop_front()) model_pkts++;
        end
      end else if (req_valid) begin
        exp_q.push_back(req_dest);
        last_q.push_back(1'b0);
        for (int n = 0; n < PF; n++) begin
          exp_q.push_back(req_payload[n*FW +: FW]);
          last_q.push_back(n == PF - 1);
        end
        hs_seen = 1'b1;
        pushes++;
      end
    end
  end

  // Issue one packet and record flits presented until write_local drops.
  // full_mask bit k drives local_full for the edge after observation k+1.
  task automatic run_packet(input logic [FW-1:0] dest, input logic [PF*FW-1:0] pay,
                            input logic [15:0] full_mask);
    obs_q.delete();
    @(posedge clk); #1;
    req_valid = 1'b1; req_dest = dest; req_payload = pay;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_dest = FW'($urandom_range(0, 15));
    req_payload = (PF*FW)'($urandom_range(0, 4095));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!write_local) break;
      obs_q.push_back(local_in);
      @(posedge clk); #1;
      local_full = full_mask[k];
    end
    local_full = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_dest = '0; req_payload = '0; local_full = 1'b0;

    // Reset held: outputs stay at reset values despite request activity.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      req_valid = ~req_valid;
      req_dest = FW'($urandom_range(0, 15));
      @(negedge clk);
      check("rst_write_local", write_local, 1'b0);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_local_in", local_in, '0);
    end
    check("rst_state", state_dbg, INJ_IDLE);
`ifdef NOC_INJ_STATS_EN
    check("rst_pkt_sent", pkt_sent, 0);
    check("rst_stall_cycles", stall_cycles, 0);
`endif
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_no_flit", write_local, 1'b0);
    end

    // Single unstalled packet.
    run_packet(4'h5, 12'hcb6, 16'h0000);
    want_q = '{4'h5, 4'h6, 4'hb, 4'hc};
    compare_seq("single_seq");
    check("single_ready_after", req_ready, 1'b1);

    // Backpressure: three stall cycles while flit 6 is presented.
    run_packet(4'h5, 12'hcb6, 16'h0007);
    want_q = '{4'h5, 4'h6, 4'h6, 4'h6, 4'h6, 4'hb, 4'hc};
    compare_seq("bp_seq");
    check("bp_ready_after", req_ready, 1'b1);
`ifdef NOC_INJ_STATS_EN
    check("stats_pkt_sent", pkt_sent, 2);
    check("stats_stall_cycles", stall_cycles, 3);
`endif

    // Back-to-back with req_valid held high.
    @(posedge clk); #1;
    req_valid = 1'b1; req_dest = 4'he; req_payload = 12'hfef;
    @(posedge clk); #1;
    req_dest = 4'hf; req_payload = 12'hefe;
    begin
      logic [FW-1:0] b2b_flit [9];
      logic          b2b_wl   [9];
      b2b_flit = '{4'he, 4'hf, 4'he, 4'hf, 4'h0, 4'hf, 4'he, 4'hf, 4'he};
      b2b_wl   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        if (i == 5) req_valid = 1'b0;
        check("b2b_wl", write_local, b2b_wl[i]);
        check("b2b_ready", req_ready, !b2b_wl[i]);
        if (b2b_wl[i]) check("b2b_flit", local_in, b2b_flit[i]);
      end
      @(negedge clk);
      check("b2b_end_wl", write_local, 1'b0);
    end

    // Reset after the head flit has been accepted.
    @(posedge clk); #1;
    req_valid = 1'b1; req_dest = 4'h3; req_payload = 12'h9a7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_head", local_in, 4'h3);
    @(posedge clk); #2;
    reset = 1'b0;
    model_flush();
    #1;
    check("mid_rst_wl", write_local, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", req_ready, 1'b1);
`ifdef NOC_INJ_STATS_EN
    check("mid_rst_pkt_sent", pkt_sent, 0);
`endif
    @(negedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    run_packet(4'h1, 12'h2d4, 16'h0000);
    want_q = '{4'h1, 4'h4, 4'hd, 4'h2};
    compare_seq("after_rst_seq");

    // Randomized traffic against the queue model.
    hs_seen = 1'b0;
    pushes  = 0;
    for (int cyc = 0; cyc < 4000 && pushes < 40; cyc++) begin
      @(posedge clk); #1;
      local_full = ($urandom_range(0, 99) < 30);
      if (hs_seen) begin
        hs_seen   = 1'b0;
        req_valid = 1'b0;
      end
      if (!req_valid && $urandom_range(0, 3) != 0) begin
        req_valid   = 1'b1;
        req_dest    = FW'($urandom_range(0, 15));
        req_payload = (PF*FW)'($urandom_range(0, 4095));
      end
    end
    @(posedge clk); #1;
    req_valid  = 1'b0;
    local_full = 1'b0;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    check("rand_drained", exp_q.size(), 0);
    @(negedge clk);
    check("rand_end_wl", write_local, 1'b0);
`ifdef NOC_INJ_STATS_EN
    check("rand_pkt_sent", pkt_sent, model_pkts);
    check("rand_stall_cycles", stall_cycles, model_stalls);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
